// File: rtl/hilo_unit_if.sv
// Execute-stage to HI/LO stage bundle: request fields driven by the pipeline,
// stall/busy/read-back returned by the HI/LO unit.
interface hilo_unit_if;
   logic        valid;
   logic [5:0]  ctrl;
   logic [31:0] r;
   logic [31:0] r2;
   logic [2:0]  op;
   logic [31:0] a;
   logic        stall;
   logic        busy;
   logic [31:0] rd_data;
   logic        rd_valid;

   modport master (
      output valid, ctrl, r, r2, op, a,
      input  stall, busy, rd_data, rd_valid
   );

   modport slave (
      input  valid, ctrl, r, r2, op, a,
      output stall, busy, rd_data, rd_valid
   );
endinterface

// File: rtl/hilo_unit.sv
// HI/LO architectural registers with a multiply-latency busy window that
// stalls any HI/LO access (or new multu) until the product is considered ready.
module hilo_unit #(
   parameter int MULT_LATENCY = 4
) (
   input  logic        clk,
   input  logic        rst,
   hilo_unit_if.slave  bus
);
   localparam logic [5:0] CTRL_MULTU = 6'h13;
   localparam logic [3:0] LAT        = 4'(MULT_LATENCY);

   typedef enum logic {IDLE, BUSY} state_e;

   state_e      state_q;
   logic [3:0]  cnt_q;
   logic [31:0] hi_q, lo_q;
   logic [31:0] rd_data_q;
   logic        rd_valid_q;

   logic mult_req, acc_req, busy;

   assign mult_req = bus.valid && (bus.ctrl == CTRL_MULTU);
   assign acc_req  = bus.valid && (bus.op >= 3'd1) && (bus.op <= 3'd4);
   assign busy     = (state_q == BUSY);

   assign bus.stall    = busy && (mult_req || acc_req);
   assign bus.busy     = busy;
   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         hi_q       <= 32'd0;
         lo_q       <= 32'd0;
         rd_data_q  <= 32'd0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // multu wins over a simultaneous HI/LO access
               if (mult_req) begin
                  hi_q    <= bus.r2;
                  lo_q    <= bus.r;
                  cnt_q   <= LAT;
                  state_q <= BUSY;
               end else if (acc_req) begin
                  case (bus.op)
                     3'd1: begin
                        rd_data_q  <= hi_q;
                        rd_valid_q <= 1'b1;
                     end
                     3'd2: begin
                        rd_data_q  <= lo_q;
                        rd_valid_q <= 1'b1;
                     end
                     3'd3:    hi_q <= bus.a;
                     3'd4:    lo_q <= bus.a;
                     default: ;
                  endcase
               end
            end
            BUSY: begin
               if (cnt_q == 4'd1) begin
                  cnt_q   <= 4'd0;
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench: reads push expected data into a queue, an independent
// monitor pops and compares on every rd_valid pulse.
module tb_hilo_unit;
   localparam int L = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   hilo_unit_if bus();

   hilo_unit #(.MULT_LATENCY(L)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // monitor: every read-back pulse must match the oldest expected value
   always @(negedge clk) begin
      if (!rst && bus.rd_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rd_unexpected: got %h expected no read", bus.rd_data);
         end else begin
            chk("rd_data", bus.rd_data, exp_q.pop_front());
         end
      end
   end

   task automatic idle_inputs();
      bus.valid = 1'b0;
      bus.ctrl  = 6'h0;
      bus.op    = 3'd0;
      bus.a     = 32'h0;
      bus.r     = 32'h0;
      bus.r2    = 32'h0;
   endtask

   // Present a request just after a rising edge, wait until it is accepted,
   // return how many cycles it was stalled (busy must be high while stalled).
   task automatic req(input logic [5:0] c, input logic [2:0] o, input logic [31:0] av,
                      input logic [31:0] rv, input logic [31:0] r2v, output int nstall);
      nstall = 0;
      bus.valid = 1'b1;
      bus.ctrl  = c;
      bus.op    = o;
      bus.a     = av;
      bus.r     = rv;
      bus.r2    = r2v;
      forever begin
         @(negedge clk);
         if (!bus.stall) break;
         chk("busy_while_stalled", {31'd0, bus.busy}, 32'd1);
         nstall++;
         if (nstall > 40) begin
            checks++;
            errors++;
            $display("FAIL stall_timeout: got %0d stall cycles expected at most 40", nstall);
            break;
         end
         @(posedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      idle_inputs();
   endtask

   task automatic rd(input logic [2:0] o, input logic [31:0] exp, input int exp_stall, input string name);
      int ns;
      exp_q.push_back(exp);
      req(6'h0, o, 32'h0, 32'h0, 32'h0, ns);
      chk(name, ns, exp_stall);
   endtask

   task automatic wr(input logic [2:0] o, input logic [31:0] av);
      int ns;
      req(6'h0, o, av, 32'h0, 32'h0, ns);
      chk("wr_stall", ns, 0);
   endtask

   task automatic multu(input logic [31:0] r2v, input logic [31:0] rv, input logic [2:0] o,
                        input logic [31:0] av, input int exp_stall);
      int ns;
      req(6'h13, o, av, rv, r2v, ns);
      chk("multu_stall", ns, exp_stall);
   endtask

   initial begin
      int ns;
      idle_inputs();
      // reset held 2 cycles with a multu presented: no stall, no busy
      bus.valid = 1'b1;
      bus.ctrl  = 6'h13;
      repeat (2) begin
         @(negedge clk);
         chk("rst_stall", {31'd0, bus.stall}, 32'd0);
         chk("rst_busy", {31'd0, bus.busy}, 32'd0);
         chk("rst_rd_valid", {31'd0, bus.rd_valid}, 32'd0);
         chk("rst_rd_data", bus.rd_data, 32'd0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle_inputs();
      rd(3'd1, 32'h0, 0, "reset_mfhi_stall");
      rd(3'd2, 32'h0, 0, "reset_mflo_stall");

      // product capture, mfhi stalls L cycles, following mflo does not
      multu(32'h00000001, 32'hFFFFFFFE, 3'd0, 32'h0, 0);
      rd(3'd1, 32'h00000001, L, "mfhi_after_multu_stall");
      rd(3'd2, 32'hFFFFFFFE, 0, "mflo_after_multu_stall");
      chk("busy_after_window", {31'd0, bus.busy}, 32'd0);

      // move-to then immediate read-back
      wr(3'd4, 32'hDEADBEEF);
      rd(3'd2, 32'hDEADBEEF, 0, "mtlo_mflo_stall");
      chk("mtlo_no_busy", {31'd0, bus.busy}, 32'd0);
      wr(3'd3, 32'hCAFEF00D);
      rd(3'd1, 32'hCAFEF00D, 0, "mthi_mfhi_stall");

      // valid low suppresses everything
      bus.valid = 1'b0;
      bus.ctrl  = 6'h13;
      bus.op    = 3'd3;
      bus.a     = 32'h55555555;
      bus.r2    = 32'h66666666;
      @(negedge clk);
      chk("novalid_stall", {31'd0, bus.stall}, 32'd0);
      @(posedge clk);
      #1;
      idle_inputs();
      chk("novalid_busy", {31'd0, bus.busy}, 32'd0);
      rd(3'd1, 32'hCAFEF00D, 0, "novalid_mfhi_stall");

      // back-to-back multu: second one waits out the first window
      multu(32'h00000009, 32'h00000003, 3'd0, 32'h0, 0);
      multu(32'h00000000, 32'h00000005, 3'd0, 32'h0, L);
      rd(3'd2, 32'h00000005, L, "b2b_mflo_stall");
      rd(3'd1, 32'h00000000, 0, "b2b_mfhi_stall");

      // multu beats a same-cycle mthi; a non-HI/LO op never stalls in BUSY
      multu(32'h0000ABCD, 32'h00000011, 3'd3, 32'h00001234, 0);
      bus.valid = 1'b1;
      bus.ctrl  = 6'h02;
      bus.op    = 3'd0;
      @(negedge clk);
      chk("aluop_busy", {31'd0, bus.busy}, 32'd1);
      chk("aluop_stall", {31'd0, bus.stall}, 32'd0);
      @(posedge clk);
      #1;
      idle_inputs();
      rd(3'd1, 32'h0000ABCD, L - 1, "prio_mfhi_stall");
      rd(3'd2, 32'h00000011, 0, "prio_mflo_stall");

      // reset in the second busy cycle discards the product
      multu(32'h00000077, 32'h00000088, 3'd0, 32'h0, 0);
      @(negedge clk);
      chk("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_busy", {31'd0, bus.busy}, 32'd0);
      @(posedge clk);
      #1;
      rd(3'd1, 32'h0, 0, "post_rst_mfhi_stall");
      rd(3'd2, 32'h0, 0, "post_rst_mflo_stall");

      repeat (3) @(posedge clk);
      chk("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/hilo_unit.md
# hilo_unit

HI/LO result register stage directly downstream of the execute-stage ALU. It captures the 64-bit `multu` product (low word on `r`, high word on `r2`) into the architectural HI and LO registers, and serves `mfhi`, `mflo`, `mthi` and `mtlo`. A programmable busy counter models the multiplier latency. It raises a pipeline stall while a HI/LO access would return a not-yet-ready product.

## Interface
- `MULT_LATENCY`, default 4: cycles HI/LO stay busy after an accepted `multu`; legal range 1..15.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `valid`  in  1  execute-stage instruction valid.
- `ctrl`  in  6  ALU control code of the execute-stage instruction; 'h13 = `multu`, all other codes are ignored by this block.
- `r`  in  32  ALU low result (LO candidate).
- `r2`  in  32  ALU high result (HI candidate).
- `op`  in  3  HI/LO access: 0 none, 1 `mfhi`, 2 `mflo`, 3 `mthi`, 4 `mtlo`, 5..7 treated as none.
- `a`  in  32  source operand (rs) for `mthi`/`mtlo`.
- `stall`  out  1  combinational; holds the execute stage this cycle.
- `busy`  out  1  registered; a multiply result is still in flight.
- `rd_data`  out  32  registered read data for `mfhi`/`mflo`.
- `rd_valid`  out  1  registered; `rd_data` valid this cycle (one-cycle pulse per read).

## Operation
- State: `hi`, `lo` (32 b each), 4-bit `cnt`, FSM {IDLE, BUSY}. `busy` = (state == BUSY).
- Mult request: `valid && ctrl=='h13`. Access request: `valid && op in 1..4`.
- `stall = busy && (mult request || access request)`. Non-HI/LO instructions never stall.
- A request is accepted on a rising edge when it is present and `stall` = 0.
- Accepted mult:
  - `hi <= r2`, `lo <= r`, `cnt <= MULT_LATENCY`, state goes to BUSY.
  - Takes priority: `op` is ignored when a mult request is present in the same cycle.
- Accepted `mthi`/`mtlo`: `hi <= a` or `lo <= a`. `cnt` and the state are unchanged (state is IDLE by construction).
- Accepted `mfhi`/`mflo`:
  - `rd_data <= hi` or `lo`, `rd_valid <= 1`.
  - Reads the value held before this edge.
- In every other cycle, `rd_valid <= 0`; `rd_data` holds its last value.
- BUSY:
  - `cnt` decrements by 1 each cycle.
  - When `cnt` == 1, the next state is IDLE and `cnt <= 0`.
  - No writes to HI/LO occur in BUSY, because every request is stalled.
- The ALU product is taken truncated as delivered: `r2:r` = `s*t` modulo 2^64. No width extension in this block.

## Timing
- Reset values: `hi` = 0, `lo` = 0, `cnt` = 0, state IDLE, `busy` = 0, `rd_data` = 0, `rd_valid` = 0.
- `stall` = 0 while `rst` is high, because `busy` is 0.
- `multu` accepted at edge k: `busy` = 1 for cycles k+1 .. k+L, where L = `MULT_LATENCY`; `busy` = 0 from cycle k+L+1.
- `mfhi` presented from cycle k+1: `stall` = 1 through cycle k+L. It is accepted at the edge ending cycle k+L+1, and `rd_valid` = 1 with data in cycle k+L+2.
- With L = 1: `busy` is high for exactly one cycle; back-to-back `multu` stalls one cycle.
- A read with no pending mult has a latency of 1 cycle, with no stall.
- Back-to-back reads produce `rd_valid` high on consecutive cycles.
- `mthi` followed by `mfhi` in the next cycle returns the new value (write at edge n, read at edge n+1).
- Reset asserted mid-BUSY: at that edge, all state returns to reset values. The captured product is lost and `busy` = 0 next cycle.
- `valid` = 0 suppresses all requests regardless of `ctrl` and `op`.

## Test plan
- Reset: hold `rst` 2 cycles, then `mfhi`, then `mflo` -> `rd_valid` pulses with `rd_data` = 0, 0; `busy` = 0 and `stall` = 0 throughout.
- L = 4: `multu` with `r2` = 'h00000001, `r` = 'hFFFFFFFE; `mfhi` the next cycle -> `stall` high exactly 4 cycles, then `rd_data` = 'h00000001; a following `mflo` -> 'hFFFFFFFE with no stall.
- `mtlo` with `a` = 'hDEADBEEF, then `mflo` next cycle -> `rd_data` = 'hDEADBEEF one cycle later; `busy` never rises.
- `multu` followed immediately by a second `multu` (`r` = 5, `r2` = 0) -> second is stalled L cycles, then accepted; a final `mflo` returns 5.
- Same-cycle `multu` with `op` = `mthi`, `a` = 'h1234 -> HI = `r2` (not 'h1234); ALU op 'h2 with `op` = 0 during BUSY -> `stall` = 0.
- `rst` pulsed in the 2nd busy cycle -> `busy` = 0 next cycle, subsequent `mfhi` returns 0 without stall.
